// File: rtl/storage_pkg.sv
// storage_pkg: shared widths, depths and word type for the register file and data memory
package storage_pkg;
  localparam int DATA_W = 16;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS = 32;
  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DEPTH_LOG2 = 8;
  localparam int MEM_DEPTH = 1 << MEM_DEPTH_LOG2;
  typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/regfile_core.sv
// regfile_core: 32x16 register array with two enable-gated combinational read ports and one clocked write port
import storage_pkg::*;
module regfile_core (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_en,
  input  logic [REG_ADDR_W-1:0] write_addr,
  input  word_t                 write_data,
  input  logic                  read_en,
  input  logic [REG_ADDR_W-1:0] read_addr_1,
  output word_t                 read_data_1,
  input  logic [REG_ADDR_W-1:0] read_addr_2,
  output word_t                 read_data_2
);
  word_t regs_q [NUM_REGS];
  word_t regs_d [NUM_REGS];
  always_comb begin
    regs_d = regs_q;
    if (write_en) regs_d[write_addr] = write_data;
  end
  always_ff @(posedge clk) begin
    if (rst) regs_q <= '{default: '0};
    else regs_q <= regs_d;
  end
  assign read_data_1 = read_en ? regs_q[read_addr_1] : '0;
  assign read_data_2 = read_en ? regs_q[read_addr_2] : '0;
endmodule

// File: rtl/storage_block.sv
// storage_block: architectural register file plus 256-word data memory with gated combinational reads and clocked writes
import storage_pkg::*;
module storage_block (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reg_write_en,
  input  logic [REG_ADDR_W-1:0] reg_write_addr,
  input  logic [DATA_W-1:0]     reg_write_data,
  input  logic                  reg_read_en,
  input  logic [REG_ADDR_W-1:0] reg_read_addr_1,
  output logic [DATA_W-1:0]     reg_read_data_1,
  input  logic [REG_ADDR_W-1:0] reg_read_addr_2,
  output logic [DATA_W-1:0]     reg_read_data_2,
  input  logic                  mem_read,
  input  logic                  mem_write_en,
  input  logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0]     mem_write_data,
  output logic [DATA_W-1:0]     mem_read_data
);
  word_t mem_q [MEM_DEPTH];
  word_t mem_d [MEM_DEPTH];
  logic [MEM_DEPTH_LOG2-1:0] mem_idx;
  logic unused_addr_hi;
  assign mem_idx = mem_addr[MEM_DEPTH_LOG2-1:0];
  assign unused_addr_hi = ^mem_addr[MEM_ADDR_W-1:MEM_DEPTH_LOG2];
  regfile_core u_regfile (
    .clk         (clk),
    .rst         (rst),
    .write_en    (reg_write_en),
    .write_addr  (reg_write_addr),
    .write_data  (reg_write_data),
    .read_en     (reg_read_en),
    .read_addr_1 (reg_read_addr_1),
    .read_data_1 (reg_read_data_1),
    .read_addr_2 (reg_read_addr_2),
    .read_data_2 (reg_read_data_2)
  );
  always_comb begin
    mem_d = mem_q;
    if (mem_write_en) mem_d[mem_idx] = mem_write_data;
  end
  always_ff @(posedge clk) begin
    if (rst) mem_q <= '{default: '0};
    else mem_q <= mem_d;
  end
  assign mem_read_data = mem_read ? mem_q[mem_idx] : '0;
endmodule

// File: tb/tb_storage_block.sv
// tb_storage_block: table-driven, directed and randomized self-checking bench for storage_block
module tb_storage_block;
  logic        clk = 0;
  logic        rst;
  logic        reg_write_en;
  logic [4:0]  reg_write_addr;
  logic [15:0] reg_write_data;
  logic        reg_read_en;
  logic [4:0]  reg_read_addr_1;
  logic [15:0] reg_read_data_1;
  logic [4:0]  reg_read_addr_2;
  logic [15:0] reg_read_data_2;
  logic        mem_read;
  logic        mem_write_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_write_data;
  logic [15:0] mem_read_data;
  int passed = 0;
  int total = 0;
  logic [15:0] regs_m [32];
  logic [15:0] mem_m [256];
  typedef struct {
    logic        rwe;
    logic [4:0]  wa;
    logic [15:0] wd;
    logic        re;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic        mr;
    logic        mwe;
    logic [15:0] ma;
    logic [15:0] md;
    logic [15:0] e1;
    logic [15:0] e2;
    logic [15:0] em;
  } vec_t;
  vec_t vecs [9];
  storage_block dut (
    .clk             (clk),
    .rst             (rst),
    .reg_write_en    (reg_write_en),
    .reg_write_addr  (reg_write_addr),
    .reg_write_data  (reg_write_data),
    .reg_read_en     (reg_read_en),
    .reg_read_addr_1 (reg_read_addr_1),
    .reg_read_data_1 (reg_read_data_1),
    .reg_read_addr_2 (reg_read_addr_2),
    .reg_read_data_2 (reg_read_data_2),
    .mem_read        (mem_read),
    .mem_write_en    (mem_write_en),
    .mem_addr        (mem_addr),
    .mem_write_data  (mem_write_data),
    .mem_read_data   (mem_read_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic idle();
    rst = 0;
    reg_write_en = 0;
    reg_write_addr = 0;
    reg_write_data = 0;
    reg_read_en = 0;
    reg_read_addr_1 = 0;
    reg_read_addr_2 = 0;
    mem_read = 0;
    mem_write_en = 0;
    mem_addr = 0;
    mem_write_data = 0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    vecs[0] = '{1, 5'd1,  16'h00AA, 1, 5'd1,  5'd2, 1, 1, 16'h0010, 16'h1357, 16'h0000, 16'h0000, 16'h0000};
    vecs[1] = '{1, 5'd2,  16'h5500, 1, 5'd1,  5'd2, 1, 0, 16'h0110, 16'h0000, 16'h00AA, 16'h0000, 16'h1357};
    vecs[2] = '{0, 5'd0,  16'h0000, 1, 5'd1,  5'd2, 0, 0, 16'h0110, 16'h0000, 16'h00AA, 16'h5500, 16'h0000};
    vecs[3] = '{1, 5'd7,  16'hCAFE, 1, 5'd7,  5'd7, 1, 1, 16'h0010, 16'h2468, 16'h0000, 16'h0000, 16'h1357};
    vecs[4] = '{0, 5'd7,  16'h1111, 1, 5'd7,  5'd1, 1, 0, 16'h0210, 16'h0000, 16'hCAFE, 16'h00AA, 16'h2468};
    vecs[5] = '{0, 5'd0,  16'h0000, 0, 5'd7,  5'd2, 0, 0, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[6] = '{1, 5'd31, 16'h8001, 1, 5'd31, 5'd0, 1, 0, 16'h00FF, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[7] = '{1, 5'd0,  16'h0042, 1, 5'd31, 5'd0, 1, 0, 16'hFF10, 16'h0000, 16'h8001, 16'h0000, 16'h2468};
    vecs[8] = '{0, 5'd0,  16'h0000, 1, 5'd31, 5'd0, 1, 0, 16'h0000, 16'h0000, 16'h8001, 16'h0042, 16'h0000};
    idle();
    rst = 1;
    tick();
    idle();
    reg_read_en = 1;
    reg_read_addr_1 = 5;
    reg_read_addr_2 = 31;
    mem_read = 1;
    mem_addr = 16'h0003;
    #1;
    chk("reset_r5", reg_read_data_1, 16'h0000);
    chk("reset_r31", reg_read_data_2, 16'h0000);
    chk("reset_mem3", mem_read_data, 16'h0000);
    for (int i = 0; i < 9; i++) begin
      idle();
      reg_write_en = vecs[i].rwe;
      reg_write_addr = vecs[i].wa;
      reg_write_data = vecs[i].wd;
      reg_read_en = vecs[i].re;
      reg_read_addr_1 = vecs[i].a1;
      reg_read_addr_2 = vecs[i].a2;
      mem_read = vecs[i].mr;
      mem_write_en = vecs[i].mwe;
      mem_addr = vecs[i].ma;
      mem_write_data = vecs[i].md;
      #1;
      chk($sformatf("vec%0d_r1", i), reg_read_data_1, vecs[i].e1);
      chk($sformatf("vec%0d_r2", i), reg_read_data_2, vecs[i].e2);
      chk($sformatf("vec%0d_mem", i), mem_read_data, vecs[i].em);
      tick();
    end
    idle();
    reg_write_en = 1;
    reg_write_addr = 5;
    reg_write_data = 16'h1234;
    mem_write_en = 1;
    mem_addr = 16'h0003;
    mem_write_data = 16'hBEEF;
    tick();
    idle();
    reg_read_en = 1;
    reg_read_addr_1 = 5;
    mem_read = 1;
    mem_addr = 16'h0003;
    #1;
    chk("pre_reset_r5", reg_read_data_1, 16'h1234);
    chk("pre_reset_mem3", mem_read_data, 16'hBEEF);
    rst = 1;
    tick();
    chk("in_reset_r5", reg_read_data_1, 16'h0000);
    rst = 0;
    #1;
    chk("post_reset_r5", reg_read_data_1, 16'h0000);
    chk("post_reset_mem3", mem_read_data, 16'h0000);
    rst = 1;
    mem_write_en = 1;
    mem_addr = 16'h0020;
    mem_write_data = 16'hFFFF;
    reg_write_en = 1;
    reg_write_addr = 9;
    reg_write_data = 16'hFFFF;
    tick();
    idle();
    mem_read = 1;
    mem_addr = 16'h0020;
    reg_read_en = 1;
    reg_read_addr_1 = 9;
    #1;
    chk("rst_prio_mem20", mem_read_data, 16'h0000);
    chk("rst_prio_r9", reg_read_data_1, 16'h0000);
    reg_write_en = 1;
    reg_write_addr = 9;
    reg_write_data = 16'h7E57;
    tick();
    reg_write_en = 0;
    reg_write_data = 16'h0BAD;
    repeat (5) tick();
    chk("hold_r9", reg_read_data_1, 16'h7E57);
    idle();
    rst = 1;
    tick();
    foreach (regs_m[i]) regs_m[i] = '0;
    foreach (mem_m[i]) mem_m[i] = '0;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      reg_write_en = 1'($urandom);
      reg_write_addr = 5'($urandom);
      reg_write_data = 16'($urandom);
      reg_read_en = ($urandom_range(0, 3) != 0);
      reg_read_addr_1 = 5'($urandom);
      reg_read_addr_2 = ($urandom_range(0, 3) == 0) ? reg_write_addr : 5'($urandom);
      mem_read = ($urandom_range(0, 3) != 0);
      mem_write_en = 1'($urandom);
      mem_addr = {8'($urandom), 4'h0, 4'($urandom)};
      mem_write_data = 16'($urandom);
      #1;
      chk("rand_r1", reg_read_data_1, reg_read_en ? regs_m[reg_read_addr_1] : 16'h0000);
      chk("rand_r2", reg_read_data_2, reg_read_en ? regs_m[reg_read_addr_2] : 16'h0000);
      chk("rand_mem", mem_read_data, mem_read ? mem_m[mem_addr % 256] : 16'h0000);
      @(posedge clk);
      if (rst) begin
        foreach (regs_m[i]) regs_m[i] = '0;
        foreach (mem_m[i]) mem_m[i] = '0;
      end else begin
        if (reg_write_en) regs_m[reg_write_addr] = reg_write_data;
        if (mem_write_en) mem_m[mem_addr % 256] = mem_write_data;
      end
      #1;
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
